// File: rtl/samples_buffer_pkg.sv
// Shared Wishbone cycle/burst encodings and FSM state type for the samples buffer.
package samples_buffer_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIC,
        ST_BURST
    } state_e;

    // Low index bits that wrap for a given burst type; zero means linear.
    function automatic logic [3:0] wrap_mask(input bte_e bte);
        case (bte)
            BTE_WRAP4:  return 4'h3;
            BTE_WRAP8:  return 4'h7;
            BTE_WRAP16: return 4'hF;
            default:    return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/samples_buffer_ram.sv
// Single-port synchronous RAM, one-cycle read latency; read register holds when not enabled.
module buffer_ram #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/samples_buffer.sv
// Wishbone B4 slave buffer for the accelerator samples port.
// Optional back-door fill port enabled by macro SAMPLES_BUFFER_FILL_EN.
module samples_buffer
    import samples_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     samples_cyc_o,
    input  logic                     samples_stb_o,
    input  logic                     samples_we_o,
    output logic                     samples_ack_i,
    input  logic [ADDR_WIDTH-1:0]    samples_addr_o,
    input  logic [DATA_WIDTH-1:0]    samples_mosi_o,
    output logic [DATA_WIDTH-1:0]    samples_miso_i,
    input  logic [2:0]               samples_cti_o,
    input  logic [1:0]               samples_bte_o
`ifdef SAMPLES_BUFFER_FILL_EN
    ,
    input  logic                     fill_valid,
    input  logic [$clog2(DEPTH)-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0]    fill_data,
    output logic                     fill_ready
`endif
);

    localparam int IW  = $clog2(DEPTH);
    localparam int LSB = $clog2(DATA_WIDTH / 8);

    state_e          state_q;
    logic            ack_q;
    logic [IW-1:0]   beat_q;
    logic [IW-1:0]   beat_d;
    logic [IW-1:0]   beat_inc;
    logic [IW-1:0]   wrap_m;
    logic [IW-1:0]   req_idx;
    logic            req;
    logic            ack;
    logic            last_beat;
    logic            ram_en;
    logic            ram_we;
    logic [IW-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic            unused_addr_bits;

    assign req       = samples_cyc_o & samples_stb_o;
    assign ack       = ack_q & req;
    assign req_idx   = samples_addr_o[LSB +: IW];
    assign last_beat = (samples_cti_o == CTI_EOB);
    assign samples_ack_i    = ack;
    assign unused_addr_bits = ^samples_addr_o;

    always_comb begin
        beat_inc = beat_q + IW'(1);
        wrap_m   = IW'(wrap_mask(bte_e'(samples_bte_o)));
        beat_d   = (wrap_m == '0) ? beat_inc : ((beat_q & ~wrap_m) | (beat_inc & wrap_m));
    end

`ifdef SAMPLES_BUFFER_FILL_EN
    assign fill_ready = ~samples_cyc_o & ~rst;
`endif

    // A write beat owns the single RAM port, so it cannot also prefetch the next beat.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = beat_q;
        ram_wdata = samples_mosi_o;
        if (!rst) begin
            if (ack && samples_we_o) begin
                ram_we = 1'b1;
            end else if (state_q == ST_IDLE && req) begin
                ram_en   = 1'b1;
                ram_addr = req_idx;
            end else if (state_q == ST_BURST && ack && !last_beat) begin
                ram_en   = 1'b1;
                ram_addr = beat_d;
            end
`ifdef SAMPLES_BUFFER_FILL_EN
            else if (fill_valid && fill_ready) begin
                ram_we    = 1'b1;
                ram_addr  = fill_addr;
                ram_wdata = fill_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        beat_q  <= req_idx;
                        ack_q   <= 1'b1;
                        state_q <= (samples_cti_o == CTI_INCR) ? ST_BURST : ST_CLASSIC;
                    end
                end
                ST_CLASSIC: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_BURST: begin
                    if (!samples_cyc_o) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!samples_stb_o) begin
                        ack_q <= 1'b0;
                    end else if (ack) begin
                        if (last_beat) begin
                            ack_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            beat_q <= beat_d;
                        end
                    end else begin
                        ack_q <= 1'b1;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    buffer_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(samples_miso_i)
    );

endmodule

// File: tb/tb_samples_buffer.sv
// Directed scoreboard bench for samples_buffer: classic, linear/wrap bursts, stalls, abort, reset.
module tb_samples_buffer;
    import samples_buffer_pkg::*;

    localparam int DW    = 256;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int LSB   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we  = 1'b0;
    logic          ack;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] mosi = '0;
    logic [DW-1:0] miso;
    logic [2:0]    cti = 3'b000;
    logic [1:0]    bte = 2'b00;
`ifdef SAMPLES_BUFFER_FILL_EN
    logic          fill_valid = 1'b0;
    logic [9:0]    fill_addr  = '0;
    logic [DW-1:0] fill_data  = '0;
    logic          fill_ready;
`endif

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    samples_buffer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .samples_cyc_o (cyc),
        .samples_stb_o (stb),
        .samples_we_o  (we),
        .samples_ack_i (ack),
        .samples_addr_o(addr),
        .samples_mosi_o(mosi),
        .samples_miso_i(miso),
        .samples_cti_o (cti),
        .samples_bte_o (bte)
`ifdef SAMPLES_BUFFER_FILL_EN
        ,
        .fill_valid    (fill_valid),
        .fill_addr     (fill_addr),
        .fill_data     (fill_data),
        .fill_ready    (fill_ready)
`endif
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int unsigned idx, input int unsigned salt);
        logic [DW-1:0] v;
        for (int i = 0; i < 8; i++) begin
            v[i*32 +: 32] = (idx * 32'h9E37_79B9) ^ (salt << 16) ^ (32'(i) << 28) ^ idx;
        end
        return v;
    endfunction

    function automatic int unsigned next_idx(input int unsigned idx, input logic [1:0] b);
        int unsigned blk;
        blk = (b == 2'd1) ? 4 : (b == 2'd2) ? 8 : (b == 2'd3) ? 16 : 0;
        if (blk == 0) return (idx + 1) % DEPTH;
        return idx - (idx % blk) + ((idx % blk) + 1) % blk;
    endfunction

    task automatic classic(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input string tag);
        int unsigned idx;
        logic [DW-1:0] e;
        idx = (a >> LSB) % DEPTH;
        cyc = 1'b1; stb = 1'b1; we = w; cti = CTI_CLASSIC; bte = 2'b00; addr = a; mosi = d;
        if (!w) exp_q.push_back(model[idx]);
        @(negedge clk);
        check({tag, " ack early"}, DW'(ack), DW'(0));
        @(negedge clk);
        check({tag, " ack"}, DW'(ack), DW'(1));
        if (w) begin
            model[idx] = d;
        end else begin
            e = exp_q.pop_front();
            check({tag, " miso"}, miso, e);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Negative abort_after/gap_at/rst_at disable that event.
    task automatic burst(input int unsigned start, input int n, input logic [1:0] b, input logic w,
                         input int unsigned salt, input int abort_after, input int gap_at,
                         input int rst_at, input string tag);
        int unsigned idx;
        logic [DW-1:0] e;
        idx = start;
        cyc = 1'b1; stb = 1'b1; we = w; bte = b;
        cti = (n == 1) ? CTI_EOB : CTI_INCR;
        addr = AW'(idx << LSB); mosi = pat(idx, salt);
        if (!w) exp_q.push_back(model[idx]);
        @(negedge clk);
        check({tag, " ack early"}, DW'(ack), DW'(0));
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check({tag, " rst ack"}, DW'(ack), DW'(0));
                check({tag, " rst miso"}, miso, DW'(0));
                @(posedge clk); #1;
                rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
                exp_q.delete();
                return;
            end
            @(negedge clk);
            check($sformatf("%s ack beat%0d", tag, k), DW'(ack), DW'(1));
            if (w) begin
                model[idx] = mosi;
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s miso beat%0d", tag, k), miso, e);
            end
            @(posedge clk); #1;
            if (k == n - 1) begin
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
                return;
            end
            idx = next_idx(idx, b);
            if (k + 1 == abort_after) begin
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
                @(negedge clk);
                check({tag, " abort ack"}, DW'(ack), DW'(0));
                @(posedge clk); #1;
                return;
            end
            if (k + 1 == gap_at) begin
                stb = 1'b0;
                @(negedge clk);
                check({tag, " gap ack"}, DW'(ack), DW'(0));
                @(posedge clk); #1;
                stb = 1'b1;
                @(negedge clk);
                check({tag, " resume ack"}, DW'(ack), DW'(0));
                @(posedge clk); #1;
            end
            cti  = (k + 1 == n - 1) ? CTI_EOB : CTI_INCR;
            addr = AW'(idx << LSB);
            mosi = pat(idx, salt);
            if (!w) exp_q.push_back(model[idx]);
        end
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 1'b1; stb = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ack", DW'(ack), DW'(0));
        check("reset miso", miso, DW'(0));
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;

        classic(32'h40, 1'b1, {32{8'hA5}}, "cl wr 0x40");
        classic(32'h40, 1'b0, '0, "cl rd 0x40");
        check("cl idx2 model", model[2], {32{8'hA5}});
        classic(32'h8045, 1'b0, '0, "cl rd alias");

        burst(0, 8, 2'b00, 1'b1, 1, -1, -1, -1, "wr lin0");
        burst(0, 8, 2'b00, 1'b0, 0, -1, -1, -1, "rd lin0");
        classic(32'h20, 1'b0, '0, "cl rd after burst");

        burst(6, 4, 2'b01, 1'b0, 0, -1, -1, -1, "rd wrap4");
        burst(8, 8, 2'b00, 1'b1, 2, -1, 3, -1, "wr lin8 gap");
        burst(13, 8, 2'b10, 1'b0, 0, -1, 2, -1, "rd wrap8 gap");
        burst(16, 16, 2'b00, 1'b1, 3, -1, -1, -1, "wr lin16");
        burst(27, 16, 2'b11, 1'b0, 0, -1, -1, -1, "rd wrap16");

        burst(16, 8, 2'b00, 1'b1, 4, 3, -1, -1, "wr abort");
        for (int i = 16; i < 20; i++) begin
            classic(AW'(i << LSB), 1'b0, '0, $sformatf("rd abort idx%0d", i));
        end

        for (int i = 32; i < 36; i++) begin
            classic(AW'(i << LSB), 1'b1, pat(i, 6), "cl prefill");
        end
        burst(32, 4, 2'b00, 1'b1, 5, -1, -1, 2, "wr rst");
        for (int i = 32; i < 36; i++) begin
            classic(AW'(i << LSB), 1'b0, '0, $sformatf("rd rst idx%0d", i));
        end

`ifdef SAMPLES_BUFFER_FILL_EN
        cyc = 1'b1; stb = 1'b0;
        fill_valid = 1'b1; fill_addr = 10'd100; fill_data = pat(100, 9);
        repeat (2) begin
            @(negedge clk);
            check("fill stalled", DW'(fill_ready), DW'(0));
            @(posedge clk); #1;
        end
        cyc = 1'b0;
        @(negedge clk);
        check("fill ready", DW'(fill_ready), DW'(1));
        model[100] = fill_data;
        @(posedge clk); #1;
        fill_valid = 1'b0;
        classic(AW'(100 << LSB), 1'b0, '0, "rd fill");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
